// File: rtl/carry_skip_subtractor_seq.sv
// carry_skip_subtractor_seq
// Block-serial two's-complement subtractor: diff = a - b - bin, one
// GROUP-bit carry-skip slice per clock, computed as a + ~b + ~bin.
// Optional build macro CSS_SKIP_COUNT_EN adds a skip_cnt output that counts
// the groups whose carry took the bypass path.
module carry_skip_subtractor_seq #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
`ifdef CSS_SKIP_COUNT_EN
  output logic             ovf,
  output logic [$clog2(WIDTH/GROUP+1)-1:0] skip_cnt
`else
  output logic             ovf
`endif
);

  localparam int NG  = WIDTH / GROUP;
  localparam int IW  = (NG > 1) ? $clog2(NG) : 1;
  localparam int SCW = $clog2(NG + 1);

  if (GROUP < 1 || (WIDTH % GROUP) != 0) begin : g_cfg_err
    $error("carry_skip_subtractor_seq: WIDTH must be a positive multiple of GROUP");
  end

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_a, r_b, r_diff;
  logic             r_a_msb, r_b_msb;
  logic             r_carry;
  logic             r_bout, r_ovf;
  logic [IW-1:0]    r_idx;
  logic [SCW-1:0]   r_skip_cnt;

  // Operands are shifted right each BUSY cycle so the active group always
  // sits in the low GROUP bits; the result shifts in from the top and is
  // fully aligned once the last group has been written.
  logic             w_accept, w_consume, w_last;
  logic [GROUP-1:0] w_a_g, w_bb_g, w_sum;
  logic [GROUP:0]   w_ripple;
  logic             w_p, w_cout;
  logic [WIDTH-1:0] w_diff_nxt;

  assign w_accept   = in_valid & in_ready;
  assign w_consume  = out_valid & out_ready;
  assign w_last     = (r_idx == IW'(NG - 1));
  assign w_a_g      = r_a[GROUP-1:0];
  assign w_bb_g     = ~r_b[GROUP-1:0];
  assign w_ripple   = {1'b0, w_a_g} + {1'b0, w_bb_g} + {{GROUP{1'b0}}, r_carry};
  assign w_sum      = w_ripple[GROUP-1:0];
  // Group propagate: when every bit propagates, carry-in passes straight out.
  assign w_p        = &(w_a_g ^ w_bb_g);
  assign w_cout     = w_p ? r_carry : w_ripple[GROUP];
  assign w_diff_nxt = WIDTH'({w_sum, r_diff} >> GROUP);

  assign diff = r_diff;
  assign bout = r_bout;
  assign ovf  = r_ovf;
`ifdef CSS_SKIP_COUNT_EN
  assign skip_cnt = r_skip_cnt;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic: IDLE -> BUSY on accept, BUSY -> DONE after last group,
  // DONE -> IDLE on consume (no accept on the consume edge).
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (in_valid)  w_state_nxt = S_BUSY;
      S_BUSY:  if (w_last)    w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default:                w_state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (r_state)
      S_IDLE:  in_ready  = 1'b1;
      S_DONE:  out_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath: capture operands on accept, then one skip group per BUSY cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a        <= '0;
      r_b        <= '0;
      r_a_msb    <= 1'b0;
      r_b_msb    <= 1'b0;
      r_diff     <= '0;
      r_carry    <= 1'b0;
      r_idx      <= '0;
      r_bout     <= 1'b0;
      r_ovf      <= 1'b0;
      r_skip_cnt <= '0;
    end else if (w_accept) begin
      r_a        <= a;
      r_b        <= b;
      r_a_msb    <= a[WIDTH-1];
      r_b_msb    <= b[WIDTH-1];
      r_carry    <= ~bin;
      r_idx      <= '0;
      r_skip_cnt <= '0;
    end else if (r_state == S_BUSY) begin
      r_a        <= r_a >> GROUP;
      r_b        <= r_b >> GROUP;
      r_diff     <= w_diff_nxt;
      r_carry    <= w_cout;
      r_idx      <= r_idx + IW'(1);
      r_skip_cnt <= r_skip_cnt + SCW'(w_p);
      if (w_last) begin
        r_bout <= ~w_cout;
        r_ovf  <= (r_a_msb != r_b_msb) && (w_sum[GROUP-1] != r_a_msb);
      end
    end
  end

`ifndef CSS_SKIP_COUNT_EN
  // Counter only feeds the optional port; keep it referenced in lean builds.
  logic w_unused_skip;
  assign w_unused_skip = ^r_skip_cnt ^ w_consume;
`else
  logic w_unused_consume;
  assign w_unused_consume = w_consume;
`endif

endmodule

// File: tb/tb_carry_skip_subtractor_seq.sv
// Self-checking bench for carry_skip_subtractor_seq (WIDTH=16, GROUP=4).
module tb_carry_skip_subtractor_seq;

  localparam int W  = 16;
  localparam int G  = 4;
  localparam int NG = W / G;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf;
`ifdef CSS_SKIP_COUNT_EN
  logic [2:0]   skip_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  carry_skip_subtractor_seq #(.WIDTH(W), .GROUP(G)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
`ifdef CSS_SKIP_COUNT_EN
    .ovf       (ovf),
    .skip_cnt  (skip_cnt)
`else
    .ovf       (ovf)
`endif
  );

  typedef struct packed {
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
    logic [2:0]   sk;
  } exp_t;

  // Reference: plain wide arithmetic; skipped groups are those where the
  // minuend and subtrahend slices are equal (a ^ ~b all ones).
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    logic [W:0] r;
    exp_t e;
    r    = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, c};
    e.d  = r[W-1:0];
    e.bo = r[W];
    e.ov = (x[W-1] != y[W-1]) && (e.d[W-1] != x[W-1]);
    e.sk = 3'd0;
    for (int g = 0; g < NG; g++)
      if (x[g*G +: G] == y[g*G +: G]) e.sk = e.sk + 3'd1;
    return e;
  endfunction

  // Present one operation (caller ensures in_ready), scramble inputs during
  // BUSY, and return cycles from the accepting edge until out_valid.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                       output int lat);
    in_valid = 1'b1; a = ta; b = tb; bin = tc;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({in_ready, out_valid, bout, ovf} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_ctl got=%b exp=1000", {in_ready, out_valid, bout, ovf});
    end
    checks++;
    if (diff !== 16'h0000) begin
      errors++;
      $display("FAIL reset_diff got=%h exp=0000", diff);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [5] = '{16'h0005, 16'h0003, 16'h0000, 16'h8000, 16'h7FFF};
    logic [W-1:0] tb [5] = '{16'h0003, 16'h0005, 16'h0000, 16'h0001, 16'hFFFF};
    logic         tc [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [W-1:0] xd [5] = '{16'h0002, 16'hFFFE, 16'hFFFF, 16'h7FFF, 16'h8000};
    logic         xb [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic         xo [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    int lat;
    for (int i = 0; i < 5; i++) begin
      do_op(ta[i], tb[i], tc[i], lat);
      checks++;
      if (lat !== NG) begin
        errors++;
        $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, NG);
      end
      checks++;
      if ({diff, bout, ovf} !== {xd[i], xb[i], xo[i]}) begin
        errors++;
        $display("FAIL dir%0d_result got=%h/%b/%b exp=%h/%b/%b", i, diff, bout, ovf, xd[i], xb[i], xo[i]);
      end
`ifdef CSS_SKIP_COUNT_EN
      checks++;
      if (skip_cnt !== model(ta[i], tb[i], tc[i]).sk) begin
        errors++;
        $display("FAIL dir%0d_skip got=%0d exp=%0d", i, skip_cnt, model(ta[i], tb[i], tc[i]).sk);
      end
`endif
      consume();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL dir%0d_release got=%b%b exp=10", i, in_ready, out_valid);
      end
    end
  endtask

`ifdef CSS_SKIP_COUNT_EN
  task automatic test_skip_cnt();
    int lat;
    do_op(16'hFFFF, 16'hFFFF, 1'b0, lat);
    checks++;
    if ({diff, bout, skip_cnt} !== {16'h0000, 1'b0, 3'd4}) begin
      errors++;
      $display("FAIL skip_all got=%h/%b/%0d exp=0000/0/4", diff, bout, skip_cnt);
    end
    consume();
    do_op(16'h1234, 16'h4321, 1'b1, lat);
    checks++;
    if (skip_cnt !== 3'd0) begin
      errors++;
      $display("FAIL skip_none got=%0d exp=0", skip_cnt);
    end
    consume();
  endtask
`endif

  task automatic test_backpressure();
    exp_t e;
    int   lat;
    int   bad;
    e = model(16'h1234, 16'h0FED, 1'b1);
    do_op(16'h1234, 16'h0FED, 1'b1, lat);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'($urandom); a = W'($urandom); b = W'($urandom);
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {diff, bout, ovf} !== {e.d, e.bo, e.ov}) bad++;
    end
    in_valid = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_hold got=%0d_bad_cycles exp=0 (diff=%h bout=%b ovf=%b exp %h/%b/%b)",
               bad, diff, bout, ovf, e.d, e.bo, e.ov);
    end
    consume();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release got=%b%b exp=10", in_ready, out_valid);
    end
  endtask

  task automatic test_mid_reset();
    int lat;
    int seen;
    in_valid = 1'b1; a = 16'hAAAA; b = 16'h5555; bin = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, bout, ovf, diff} !== {4'b1000, 16'h0000}) begin
      errors++;
      $display("FAIL midrst_clear got=%b/%h exp=1000/0000", {in_ready, out_valid, bout, ovf}, diff);
    end
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL midrst_noresult got=%0d exp=0", seen);
    end
    do_op(16'h0010, 16'h0001, 1'b0, lat);
    checks++;
    if (lat !== NG || diff !== 16'h000F || bout !== 1'b0) begin
      errors++;
      $display("FAIL midrst_next got=%0d/%h/%b exp=%0d/000f/0", lat, diff, bout, NG);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   lat;
    do_op(16'hBEEF, 16'h1EE7, 1'b0, lat);
    e = model(16'hC0DE, 16'hFACE, 1'b1);
    in_valid = 1'b1; a = 16'hC0DE; b = 16'hFACE; bin = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_no_same_edge got=%b%b exp=10", in_ready, out_valid);
    end
    do_op(16'hC0DE, 16'hFACE, 1'b1, lat);
    checks++;
    if (lat !== NG || {diff, bout, ovf} !== {e.d, e.bo, e.ov}) begin
      errors++;
      $display("FAIL b2b_second got=%0d/%h/%b/%b exp=%0d/%h/%b/%b", lat, diff, bout, ovf, NG, e.d, e.bo, e.ov);
    end
    consume();
  endtask

  task automatic test_random();
    exp_t         e;
    int           lat;
    logic [W-1:0] ra, rb;
    logic         rc;
    for (int n = 0; n < 40; n++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      if (n % 5 == 0) rb = ra ^ W'(16'h000F << (4 * (n % 4)));
      if (n % 7 == 0) rb = ra;
      e = model(ra, rb, rc);
      do_op(ra, rb, rc, lat);
      for (int s = 0; s < int'($urandom_range(0, 3)); s++) begin
        @(posedge clk); #1;
      end
      checks++;
      if (lat !== NG) begin
        errors++;
        $display("FAIL rnd%0d_latency got=%0d exp=%0d", n, lat, NG);
      end
      checks++;
      if ({diff, bout, ovf} !== {e.d, e.bo, e.ov}) begin
        errors++;
        $display("FAIL rnd%0d_result a=%h b=%h bin=%b got=%h/%b/%b exp=%h/%b/%b",
                 n, ra, rb, rc, diff, bout, ovf, e.d, e.bo, e.ov);
      end
`ifdef CSS_SKIP_COUNT_EN
      checks++;
      if (skip_cnt !== e.sk) begin
        errors++;
        $display("FAIL rnd%0d_skip got=%0d exp=%0d", n, skip_cnt, e.sk);
      end
`endif
      consume();
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
`ifdef CSS_SKIP_COUNT_EN
    test_skip_cnt();
`endif
    test_backpressure();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
